// File: rtl/mod_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_exp_ctrl_if
//  Purpose  : Handshake/operand bundle between the modular-exponentiation
//             sequencer and the Montgomery product stage (mon_prod).
//  Ports    : master (sequencer side)
//               out: mp_start, mp_A, mp_B, mp_M, mp_num_words
//               in : mp_stop, mp_P
//             slave (mon_prod side) is the mirror image.
//  Revision : 1.0  initial release
// ============================================================================
interface mod_exp_ctrl_if #(
    parameter int bitLen     = 64,
    parameter int countWidth = 5
);
    logic                  mp_start;
    logic [bitLen-1:0]     mp_A;
    logic [bitLen-1:0]     mp_B;
    logic [bitLen-1:0]     mp_M;
    logic [countWidth-1:0] mp_num_words;
    logic                  mp_stop;
    logic [bitLen:0]       mp_P;

    modport master (
        output mp_start, mp_A, mp_B, mp_M, mp_num_words,
        input  mp_stop, mp_P
    );

    modport slave (
        input  mp_start, mp_A, mp_B, mp_M, mp_num_words,
        output mp_stop, mp_P
    );
endinterface
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mod_exp_ctrl
//  Purpose  : Computes RESULT = MSG^E mod M by sequencing Montgomery products
//             on mon_prod: domain entry (Xb, Ab), left-to-right
//             square-and-multiply over every exponent bit, and domain exit.
//             Each product is conditionally reduced by M before reuse.
//  Ports    : clk, reset (async, active-high)
//             start, MSG, E, M, R2, num_words  - operation request
//             busy, done, RESULT               - status / result
//             mp (mod_exp_ctrl_if.master)      - mon_prod handshake/operands
//  Revision : 1.0  initial release
// ============================================================================
module mod_exp_ctrl #(
    parameter int bitLen     = 64,
    parameter int countWidth = 5,
    parameter int expLen     = 64
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   start,
    input  wire  [bitLen-1:0]     MSG,
    input  wire  [expLen-1:0]     E,
    input  wire  [bitLen-1:0]     M,
    input  wire  [bitLen-1:0]     R2,
    input  wire  [countWidth-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [bitLen-1:0]     RESULT,
    mod_exp_ctrl_if.master        mp
);

    localparam int c_IDX_W = (expLen > 1) ? $clog2(expLen) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(expLen - 1);
    localparam logic [bitLen-1:0]  c_ONE     = bitLen'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_XBAR = 3'd1,
        S_ABAR = 3'd2,
        S_SQR  = 3'd3,
        S_MUL  = 3'd4,
        S_EXIT = 3'd5,
        S_DONE = 3'd6
    } op_t;

    // Sub-phase of a single mon_prod call.
    typedef enum logic [1:0] {
        P_ISSUE = 2'd0,
        P_WAIT  = 2'd1,
        P_GAP   = 2'd2
    } phase_t;

    op_t                   r_op;
    phase_t                r_phase;
    logic [bitLen-1:0]     r_msg;
    logic [expLen-1:0]     r_e;
    logic [bitLen-1:0]     r_m;
    logic [bitLen-1:0]     r_r2;
    logic [countWidth-1:0] r_nw;
    logic [bitLen-1:0]     r_xb;
    logic [bitLen-1:0]     r_ab;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic [bitLen-1:0]     r_result;
    logic                  r_mp_start;
    logic [bitLen-1:0]     r_mp_a;
    logic [bitLen-1:0]     r_mp_b;

    op_t                   w_next_op;
    logic                  w_idx_dec;
    logic [bitLen-1:0]     w_next_a;
    logic [bitLen-1:0]     w_next_b;
    logic [bitLen:0]       w_p_minus_m;
    logic [bitLen-1:0]     w_red;

    // mon_prod guarantees P < 2M, so one conditional subtract fully reduces.
    assign w_p_minus_m = mp.mp_P - {1'b0, r_m};
    assign w_red       = (mp.mp_P >= {1'b0, r_m}) ? w_p_minus_m[bitLen-1:0]
                                                  : mp.mp_P[bitLen-1:0];

    // Successor operation and its operands, evaluated in GAP once the
    // destination register of the finished call already holds its result.
    always_comb begin
        w_next_op = S_DONE;
        w_idx_dec = 1'b0;
        w_next_a  = '0;
        w_next_b  = '0;
        case (r_op)
            S_XBAR: w_next_op = S_ABAR;
            S_ABAR: w_next_op = S_SQR;
            S_SQR: begin
                if (r_e[r_idx]) begin
                    w_next_op = S_MUL;
                end else if (r_idx == '0) begin
                    w_next_op = S_EXIT;
                end else begin
                    w_next_op = S_SQR;
                    w_idx_dec = 1'b1;
                end
            end
            S_MUL: begin
                if (r_idx == '0) begin
                    w_next_op = S_EXIT;
                end else begin
                    w_next_op = S_SQR;
                    w_idx_dec = 1'b1;
                end
            end
            default: w_next_op = S_DONE;
        endcase
        case (w_next_op)
            S_ABAR: begin w_next_a = r_r2; w_next_b = c_ONE; end
            S_SQR:  begin w_next_a = r_ab; w_next_b = r_ab;  end
            S_MUL:  begin w_next_a = r_ab; w_next_b = r_xb;  end
            S_EXIT: begin w_next_a = r_ab; w_next_b = c_ONE; end
            default: begin w_next_a = '0; w_next_b = '0; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= S_IDLE;
            r_phase    <= P_ISSUE;
            r_msg      <= '0;
            r_e        <= '0;
            r_m        <= '0;
            r_r2       <= '0;
            r_nw       <= '0;
            r_xb       <= '0;
            r_ab       <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_mp_start <= 1'b0;
            r_mp_a     <= '0;
            r_mp_b     <= '0;
        end else begin
            case (r_op)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_msg      <= MSG;
                        r_e        <= E;
                        r_m        <= M;
                        r_r2       <= R2;
                        r_nw       <= num_words;
                        r_idx      <= c_IDX_TOP;
                        r_busy     <= 1'b1;
                        r_op       <= S_XBAR;
                        r_phase    <= P_ISSUE;
                        // First call issues straight from the request inputs
                        // because the operand registers load on this edge.
                        r_mp_start <= 1'b1;
                        r_mp_a     <= MSG;
                        r_mp_b     <= R2;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_op   <= S_IDLE;
                end
                default: begin
                    case (r_phase)
                        P_ISSUE: r_phase <= P_WAIT;
                        P_WAIT: begin
                            if (mp.mp_stop) begin
                                case (r_op)
                                    S_XBAR:  r_xb     <= w_red;
                                    S_EXIT:  r_result <= w_red;
                                    default: r_ab     <= w_red;
                                endcase
                                r_mp_start <= 1'b0;
                                r_phase    <= P_GAP;
                            end
                        end
                        P_GAP: begin
                            // Only move on once mon_prod has seen start low
                            // and released stop, so a stale stop is never
                            // mistaken for the next call's completion.
                            if (!mp.mp_stop) begin
                                r_phase <= P_ISSUE;
                                if (w_next_op == S_DONE) begin
                                    r_op   <= S_DONE;
                                    r_done <= 1'b1;
                                    r_busy <= 1'b0;
                                    r_mp_a <= '0;
                                    r_mp_b <= '0;
                                end else begin
                                    r_op       <= w_next_op;
                                    r_mp_start <= 1'b1;
                                    r_mp_a     <= w_next_a;
                                    r_mp_b     <= w_next_b;
                                    if (w_idx_dec) begin
                                        r_idx <= r_idx - 1'b1;
                                    end
                                end
                            end
                        end
                        default: r_phase <= P_ISSUE;
                    endcase
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign RESULT          = r_result;
    assign mp.mp_start     = r_mp_start;
    assign mp.mp_A         = r_mp_a;
    assign mp.mp_B         = r_mp_b;
    assign mp.mp_M         = r_m;
    assign mp.mp_num_words = r_nw;

endmodule
`default_nettype wire

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Sequencer that computes RESULT = MSG^E mod M by driving the Montgomery product stage (`mon_prod`) through a start/stop handshake. It supplies mon_prod's operand ports, consumes its (bitLen+1)-bit product, and conditionally reduces that product by M before reuse. It sits directly above `mon_prod` in the RSA datapath. It performs Montgomery-domain entry, left-to-right square-and-multiply over all exponent bits, and the final exit from the Montgomery domain.

## Interface
- bitLen, 64, operand/modulus width; equals mon_prod's bitLen
- countWidth, 5, width of num_words; equals mon_prod's countWidth
- expLen, 64, exponent width in bits
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- MSG  input  bitLen  message, must be < M
- E  input  expLen  exponent
- M  input  bitLen  odd modulus
- R2  input  bitLen  R^2 mod M, where R is mon_prod's Montgomery radix
- num_words  input  countWidth  passed through to mon_prod
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; RESULT is valid from this cycle onward
- RESULT  output  bitLen  MSG^E mod M; holds until the next accepted start
- mp_start  output  1  to mon_prod start
- mp_A, mp_B, mp_M  output  bitLen  to mon_prod operands
- mp_num_words  output  countWidth  to mon_prod num_words
- mp_stop  input  1  from mon_prod stop
- mp_P  input  bitLen+1  from mon_prod P; guaranteed < 2M

## Operation
- Accept: in IDLE with start=1, register MSG, E, M, R2 and num_words, set busy, and go to XBAR. Later input changes have no effect.
- Operation sequence, where MP(a,b) denotes one mon_prod call and red() denotes reduction:
  - XBAR: Xb = red(MP(MSG, R2))
  - ABAR: Ab = red(MP(R2, 1)), which equals R mod M
  - For i = expLen-1 down to 0:
    - SQR: Ab = red(MP(Ab, Ab))
    - if E[i]=1, MUL: Ab = red(MP(Ab, Xb))
  - EXIT: RESULT = red(MP(Ab, 1))
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Reduction: red(P) = P − M if P ≥ M, else P. The comparison is done at bitLen+1 bits and the result is truncated to bitLen bits. Reduction is combinational on mp_P at capture time.
- Per-call sub-phases:
  - ISSUE: drive mp_A and mp_B; mp_start=1.
  - WAIT: hold mp_start=1 and the operands stable until mp_stop=1.
  - CAPTURE: in the first cycle with mp_stop=1, write red(mp_P) to its destination register and drop mp_start to 0.
  - GAP: hold mp_start=0 for at least one cycle and until mp_stop=0, then advance to the next operation.
- Exponent bit index is a down-counter from expLen-1. The loop ends after the SQR/MUL step for bit 0; the index does not wrap.
- mp_M and mp_num_words always reflect the registered values. When idle, mp_A and mp_B are 0.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE, busy=0, done=0, RESULT=0, mp_start=0, mp_A=mp_B=mp_M=0, mp_num_words=0, all internal registers 0.
- Reset mid-operation: abort at once, with mp_start dropping to 0 asynchronously. No done is produced; a new start is accepted after reset deasserts.
- Number of mon_prod calls = 3 + expLen + popcount(E).
- Each call costs (mon_prod latency) + 1 ISSUE cycle + 1 CAPTURE cycle + at least 1 GAP cycle.
- start is ignored while busy=1 or done=1. start held high across DONE begins a new operation in the cycle after DONE, reached via IDLE.
- E=0: only XBAR, ABAR, the expLen squarings and EXIT run, giving RESULT = 1 mod M (0 when M=1).
- mp_stop=1 outside WAIT is ignored. mp_stop already high on entering WAIT is not a valid capture, because the GAP phase guarantees it was seen low first.

## Test plan
Benches use a behavioural mon_prod model with R = 2^bitLen, a variable latency of 1–20 cycles, and un-reduced outputs in [M, 2M) whenever possible.
- MSG=2, E=10, M=253, R2 = 2^128 mod 253 -> RESULT=12; done pulses exactly once; call count = 3+64+2 = 69.
- MSG=3, E=0, M=253 -> RESULT=1; no MUL calls issued.
- MSG=252, E=2, M=253 -> RESULT=1; exercises the P≥M subtract path on every call.
- MSG=216, E=123, M=253 -> RESULT equals the golden value pow(216,123,253); mp_start is never high during GAP, and the operands are stable throughout WAIT.
- Assert reset during the tenth call -> all outputs go to their reset values immediately; a new start with MSG=2, E=10 completes with RESULT=12.
- Pulse start while busy, and hold start high through DONE -> the busy pulse is ignored; the held start launches a second operation whose RESULT matches the first.
